// File: rtl/ahb_apb_bridge.sv
// AHB-Lite single-transfer slave bridged onto an APB3 master port.
// One transfer in flight; Hreadyout stretches the AHB data phase.
module ahb_apb_bridge #(
    parameter int          NUM_SLV   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] SLV_SIZE  = 32'h0100_0000
) (
    input  logic               clk,
    input  logic               Hreset,
    input  logic [1:0]         Htrans,
    input  logic [2:0]         Hsize,
    input  logic               Hreadyin,
    input  logic               Hwrite,
    input  logic [31:0]        Haddr,
    input  logic [31:0]        Hwdata,
    output logic               Hreadyout,
    output logic               Hresp,
    output logic [31:0]        Hrdata,
    output logic [NUM_SLV-1:0] Pselx,
    output logic               Penable,
    output logic               Pwrite,
    output logic [31:0]        Paddr,
    output logic [31:0]        Pwdata,
    input  logic [31:0]        Prdata,
    input  logic               Pready
);

    localparam int SHIFT = $clog2(SLV_SIZE);
    localparam int IDXW  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam logic [32:0] WIN_END =
        {1'b0, BASE_ADDR} + (33'(NUM_SLV) * {1'b0, SLV_SIZE});

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_SETUP,
        S_ENABLE,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [31:0]        r_addr;
    logic               r_write;
    logic [IDXW-1:0]    r_idx;
    logic               r_hreadyout;
    logic               r_hresp;
    logic [31:0]        r_hrdata;
    logic [NUM_SLV-1:0] r_pselx;
    logic               r_penable;
    logic               r_pwrite;
    logic [31:0]        r_paddr;
    logic [31:0]        r_pwdata;

    logic [31:0]        w_off;
    logic               w_valid;
    logic               w_accept;
    logic [IDXW-1:0]    w_idx;
    logic [NUM_SLV-1:0] w_sel;
    logic               w_unused_ok;

    assign w_off    = Haddr - BASE_ADDR;
    assign w_valid  = (Haddr >= BASE_ADDR)
                   && ({1'b0, Haddr} < WIN_END)
                   && (Hsize <= 3'b010);
    assign w_accept = (r_state == S_IDLE) && Hreadyin && Htrans[1];
    assign w_idx    = w_off[SHIFT +: IDXW];

    // Only NONSEQ/SEQ matter, and only the region bits of the offset.
    assign w_unused_ok = &{1'b0, Htrans[0], w_off};

    // One-hot select for the latched peripheral index.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_sel[i] = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (Hreset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_valid ? S_LATCH : S_ERR1;
                end
            end
            S_LATCH:  w_next = S_SETUP;
            S_SETUP:  w_next = S_ENABLE;
            S_ENABLE: w_next = Pready ? S_IDLE : S_ENABLE;
            S_ERR1:   w_next = S_ERR2;
            S_ERR2:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Registered outputs, computed from the state being entered.
    always_ff @(posedge clk) begin
        if (Hreset) begin
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_idx       <= '0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_hrdata    <= '0;
            r_pselx     <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
        end else begin
            r_hreadyout <= (w_next == S_IDLE) || (w_next == S_ERR2);
            r_hresp     <= (w_next == S_ERR1) || (w_next == S_ERR2);
            if (w_accept && w_valid) begin
                r_addr  <= Haddr;
                r_write <= Hwrite;
                r_idx   <= w_idx;
            end
            if (r_state == S_LATCH) begin
                if (r_write) begin
                    r_pwdata <= Hwdata;
                end
                r_paddr  <= r_addr;
                r_pwrite <= r_write;
                r_pselx  <= w_sel;
            end
            if (r_state == S_SETUP) begin
                r_penable <= 1'b1;
            end
            if ((r_state == S_ENABLE) && Pready) begin
                r_pselx   <= '0;
                r_penable <= 1'b0;
                if (!r_write) begin
                    r_hrdata <= Prdata;
                end
            end
        end
    end

    assign Hreadyout = r_hreadyout;
    assign Hresp     = r_hresp;
    assign Hrdata    = r_hrdata;
    assign Pselx     = r_pselx;
    assign Penable   = r_penable;
    assign Pwrite    = r_pwrite;
    assign Paddr     = r_paddr;
    assign Pwdata    = r_pwdata;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed bench for ahb_apb_bridge with an expected-transfer queue.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ahb_apb_bridge;

    logic        clk;
    logic        Hreset;
    logic [1:0]  Htrans;
    logic [2:0]  Hsize;
    logic        Hreadyin;
    logic        Hwrite;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic        Hreadyout;
    logic        Hresp;
    logic [31:0] Hrdata;
    logic [3:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic [31:0] rdata;
        logic        err;
    } txn_t;

    txn_t        q[$];
    logic [31:0] last_rd = 32'h0;

    ahb_apb_bridge #(
        .NUM_SLV  (4),
        .BASE_ADDR(32'h8000_0000),
        .SLV_SIZE (32'h0100_0000)
    ) dut (
        .clk      (clk),
        .Hreset   (Hreset),
        .Htrans   (Htrans),
        .Hsize    (Hsize),
        .Hreadyin (Hreadyin),
        .Hwrite   (Hwrite),
        .Haddr    (Haddr),
        .Hwdata   (Hwdata),
        .Hreadyout(Hreadyout),
        .Hresp    (Hresp),
        .Hrdata   (Hrdata),
        .Pselx    (Pselx),
        .Penable  (Penable),
        .Pwrite   (Pwrite),
        .Paddr    (Paddr),
        .Pwdata   (Pwdata),
        .Prdata   (Prdata),
        .Pready   (Pready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference decode of the bridged window and read-data history.
    function automatic txn_t model(input logic [31:0] a, input logic w,
                                  input logic [2:0] sz,
                                  input logic [31:0] wd,
                                  input logic [31:0] rd);
        txn_t        t;
        logic [31:0] off;
        off     = a - 32'h8000_0000;
        t.addr  = a;
        t.wr    = w;
        t.wdata = wd;
        t.err   = (a < 32'h8000_0000) || (a >= 32'h8400_0000)
               || (sz > 3'd2);
        t.sel   = t.err ? 4'b0000 : (4'b0001 << off[25:24]);
        if (!w && !t.err) begin
            last_rd = rd;
        end
        t.rdata = last_rd;
        return t;
    endfunction

    // Address phase in the current cycle; returns in the cycle the
    // bridge is back in IDLE, so the next call can go back-to-back.
    task automatic run_xfer(input string nm, input logic [31:0] a,
                            input logic w, input logic [2:0] sz,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input int nw);
        txn_t e;
        int   k;
        q.push_back(model(a, w, sz, wd, rd));
        chk({nm, "_addr_rdy"}, 32'(Hreadyout), 32'h1);
        Htrans   = 2'b10;
        Haddr    = a;
        Hwrite   = w;
        Hsize    = sz;
        Hreadyin = 1'b1;
        step();
        Htrans = 2'b00;
        Haddr  = 32'h0;
        Hwdata = wd;
        e = q.pop_front();
        if (e.err) begin
            chk({nm, "_err1_rdy"}, 32'(Hreadyout), 32'h0);
            chk({nm, "_err1_resp"}, 32'(Hresp), 32'h1);
            chk({nm, "_err1_sel"}, 32'(Pselx), 32'h0);
            step();
            chk({nm, "_err2_rdy"}, 32'(Hreadyout), 32'h1);
            chk({nm, "_err2_resp"}, 32'(Hresp), 32'h1);
            chk({nm, "_err2_sel"}, 32'(Pselx), 32'h0);
            step();
            chk({nm, "_post_rdy"}, 32'(Hreadyout), 32'h1);
            chk({nm, "_post_resp"}, 32'(Hresp), 32'h0);
            chk({nm, "_post_sel"}, 32'(Pselx), 32'h0);
        end else begin
            chk({nm, "_latch_rdy"}, 32'(Hreadyout), 32'h0);
            chk({nm, "_latch_sel"}, 32'(Pselx), 32'h0);
            k = 0;
            while ((Pselx == 4'b0) && (k < 8)) begin
                step();
                k++;
            end
            chk({nm, "_setup_lat"}, 32'(k), 32'h1);
            chk({nm, "_setup_sel"}, 32'(Pselx), 32'(e.sel));
            chk({nm, "_setup_pen"}, 32'(Penable), 32'h0);
            chk({nm, "_setup_paddr"}, Paddr, e.addr);
            chk({nm, "_setup_pwrite"}, 32'(Pwrite), 32'(e.wr));
            chk({nm, "_setup_rdy"}, 32'(Hreadyout), 32'h0);
            step();
            for (int i = 0; i <= nw; i++) begin
                chk({nm, "_en_pen"}, 32'(Penable), 32'h1);
                chk({nm, "_en_sel"}, 32'(Pselx), 32'(e.sel));
                chk({nm, "_en_paddr"}, Paddr, e.addr);
                chk({nm, "_en_rdy"}, 32'(Hreadyout), 32'h0);
                if (e.wr) begin
                    chk({nm, "_en_pwdata"}, Pwdata, e.wdata);
                end
                Pready = (i == nw);
                Prdata = rd;
                step();
            end
            Pready = 1'b0;
            Prdata = 32'h0;
            chk({nm, "_done_rdy"}, 32'(Hreadyout), 32'h1);
            chk({nm, "_done_resp"}, 32'(Hresp), 32'h0);
            chk({nm, "_done_sel"}, 32'(Pselx), 32'h0);
            chk({nm, "_done_pen"}, 32'(Penable), 32'h0);
            chk({nm, "_done_hrdata"}, Hrdata, e.rdata);
        end
    endtask

    task automatic idle(input string nm, input int n,
                        input logic [1:0] tr, input logic [31:0] a);
        Htrans   = tr;
        Haddr    = a;
        Hwrite   = 1'b1;
        Hsize    = 3'b010;
        Hreadyin = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            chk({nm, "_rdy"}, 32'(Hreadyout), 32'h1);
            chk({nm, "_resp"}, 32'(Hresp), 32'h0);
            chk({nm, "_sel"}, 32'(Pselx), 32'h0);
            chk({nm, "_pen"}, 32'(Penable), 32'h0);
        end
        Htrans = 2'b00;
        Haddr  = 32'h0;
    endtask

    initial begin
        Hreset   = 1'b1;
        Htrans   = 2'b00;
        Hsize    = 3'b010;
        Hreadyin = 1'b1;
        Hwrite   = 1'b0;
        Haddr    = 32'h0;
        Hwdata   = 32'h0;
        Prdata   = 32'h0;
        Pready   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", 32'(Hreadyout), 32'h1);
        chk("rst_resp", 32'(Hresp), 32'h0);
        chk("rst_hrdata", Hrdata, 32'h0);
        chk("rst_sel", 32'(Pselx), 32'h0);
        chk("rst_pen", 32'(Penable), 32'h0);
        chk("rst_pwrite", 32'(Pwrite), 32'h0);
        chk("rst_paddr", Paddr, 32'h0);
        chk("rst_pwdata", Pwdata, 32'h0);
        Hreset = 1'b0;
        step();

        run_xfer("wr1", 32'h8100_0010, 1'b1, 3'b010,
                 32'hDEAD_BEEF, 32'h0, 0);
        idle("idle", 5, 2'b00, 32'h8000_0000);
        idle("busy", 5, 2'b01, 32'h8200_0000);

        run_xfer("rdw", 32'h8300_0004, 1'b0, 3'b010,
                 32'h0, 32'h1234_5678, 2);
        idle("gap1", 1, 2'b00, 32'h0);

        run_xfer("b2b_wr", 32'h8000_0000, 1'b1, 3'b010,
                 32'hA5A5_0001, 32'h0, 0);
        run_xfer("b2b_rd", 32'h8000_0004, 1'b0, 3'b010,
                 32'h0, 32'hCAFE_F00D, 0);
        idle("gap2", 1, 2'b00, 32'h0);

        run_xfer("err_oow", 32'h8400_0000, 1'b1, 3'b010,
                 32'h1111_1111, 32'h0, 0);
        run_xfer("err_size", 32'h8000_0008, 1'b0, 3'b011,
                 32'h0, 32'h0, 0);
        run_xfer("err_low", 32'h7FFF_FFFC, 1'b0, 3'b010,
                 32'h0, 32'h0, 0);
        run_xfer("byte_wr", 32'h8200_0001, 1'b1, 3'b000,
                 32'h0000_00AB, 32'h0, 1);
        run_xfer("top_rd", 32'h83FF_FFFC, 1'b0, 3'b001,
                 32'h0, 32'h5A5A_C3C3, 0);

        Htrans = 2'b10;
        Haddr  = 32'h8200_0040;
        Hwrite = 1'b0;
        Hsize  = 3'b010;
        step();
        Htrans = 2'b00;
        Haddr  = 32'h0;
        step();
        chk("rstm_setup_sel", 32'(Pselx), 32'h4);
        step();
        chk("rstm_en_pen", 32'(Penable), 32'h1);
        Pready = 1'b0;
        Hreset = 1'b1;
        step();
        Hreset  = 1'b0;
        last_rd = 32'h0;
        chk("rstm_sel", 32'(Pselx), 32'h0);
        chk("rstm_pen", 32'(Penable), 32'h0);
        chk("rstm_rdy", 32'(Hreadyout), 32'h1);
        chk("rstm_resp", 32'(Hresp), 32'h0);
        chk("rstm_hrdata", Hrdata, 32'h0);
        idle("rstm_idle", 2, 2'b00, 32'h0);

        run_xfer("wr_after", 32'h8000_0010, 1'b1, 3'b010,
                 32'h0BAD_F00D, 32'h0, 0);
        idle("tail", 2, 2'b00, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_apb_bridge.md
Name: ahb_apb_bridge

Overview:
- AHB-Lite slave responder that converts each AHB single transfer into one APB3 transfer. It is the counterpart of the bench-side AHB master agent.
- The AHB side responds to the master's Htrans, Haddr, Hwrite, Hsize, Hwdata and Hreadyin.
- The APB side drives NUM_SLV one-hot peripheral selects and waits on Pready.
- Only one transfer is in flight at a time. Hreadyout stretches the AHB data phase until the APB transfer completes.

Parameters:
- NUM_SLV, 4, number of APB peripherals (one-hot Pselx width).
- BASE_ADDR, 32'h8000_0000, start of the bridged address window.
- SLV_SIZE, 32'h0100_0000, bytes per peripheral region; must be a power of 2.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- Hreset  input  1  synchronous, active-high reset.
- Htrans  input  2  AHB transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- Hsize  input  3  AHB transfer size.
- Hreadyin  input  1  bus-level HREADY from the interconnect.
- Hwrite  input  1  1 = write, 0 = read.
- Haddr  input  32  AHB address, sampled in the address phase.
- Hwdata  input  32  AHB write data, valid in the data phase.
- Hreadyout  output  1  slave ready; 0 stretches the data phase.
- Hresp  output  1  0 = OKAY, 1 = ERROR.
- Hrdata  output  32  read data, valid when Hreadyout=1 ends a read.
- Pselx  output  NUM_SLV  one-hot APB select.
- Penable  output  1  APB enable (access phase).
- Pwrite  output  1  APB direction.
- Paddr  output  32  APB address.
- Pwdata  output  32  APB write data.
- Prdata  input  32  APB read data.
- Pready  input  1  APB ready; extends the access phase.

Behaviour:
- All outputs are registered.
- Reset values: Hreadyout=1, Hresp=0, Hrdata=0, Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0. State = IDLE.
- Accept condition at an edge: state IDLE, Hreadyin=1, Htrans[1]=1.
  - BUSY or IDLE Htrans produces no transfer; the bridge stays in IDLE with OKAY.
- Address decode is done on the accepted Haddr.
  - Valid when BASE_ADDR <= Haddr < BASE_ADDR + NUM_SLV*SLV_SIZE and Hsize <= 3'b010.
  - Slave index = (Haddr - BASE_ADDR) / SLV_SIZE.
- States: IDLE, LATCH, SETUP, ENABLE, ERR1, ERR2.
- IDLE: Hreadyout=1, Hresp=0.
  - Valid accept: register Haddr, Hwrite and the slave index, then go to LATCH.
  - Invalid accept: go to ERR1.
- LATCH (1 cycle): Hreadyout=0. Register Hwdata into Pwdata if the transfer is a write. Go to SETUP.
- SETUP (1 cycle): Pselx[idx]=1, Penable=0, and Paddr/Pwrite are driven. Go to ENABLE.
- ENABLE: Pselx[idx]=1, Penable=1.
  - Pready=0: stay in ENABLE; all APB outputs are held stable.
  - Pready=1: register Prdata into Hrdata (reads only), drop Pselx and Penable, go to IDLE. Hreadyout=1 in the following cycle.
- Minimum latency: address phase at edge 0, APB setup in cycle 2, access in cycle 3, AHB data phase completes in cycle 4. This gives 3 wait states when Pready is immediate; each Pready=0 cycle adds one.
- Back-to-back: the IDLE cycle that completes a data phase (Hreadyout=1) may accept the next address phase.
- Hrdata holds its last read value until the next read completes. Writes leave Hrdata unchanged.
- ERR1: Hreadyout=0, Hresp=1. Go to ERR2.
- ERR2: Hreadyout=1, Hresp=1. Go to IDLE.
  - No address phase is accepted in ERR2; the master is required to cancel after an ERROR.
  - No APB activity occurs for an errored transfer.
- Paddr = full registered Haddr; no offset is subtracted.
- Sizes of byte and halfword are passed through as full-word APB accesses.
- Hreset=1 in any state forces all outputs to their reset values at that edge. Any in-flight APB transfer is abandoned; Pselx and Penable drop immediately.

Test Plan:
- Single write: accept Haddr=32'h8100_0010, Hwrite=1, Hwdata=32'hDEAD_BEEF with Pready=1 -> cycle 2 Pselx=4'b0010, Penable=0, Paddr=32'h8100_0010; cycle 3 Penable=1, Pwdata=32'hDEAD_BEEF; Hreadyout=0 in cycles 1–3, 1 in cycle 4, Hresp=0.
- Read with waits: Haddr=32'h8300_0004, Hwrite=0, Pready=0 for 2 cycles, Prdata=32'h1234_5678 -> ENABLE lasts 3 cycles; Hrdata=32'h1234_5678 with Hreadyout=1 in cycle 6.
- Back-to-back: write to 32'h8000_0000, then a read of 32'h8000_0004 presented in the completion cycle -> the second SETUP starts 2 cycles later; Pselx=4'b0001 for both transfers.
- Errors: Haddr=32'h8400_0000 (out of window), or Hsize=3'b011 -> Hreadyout=0/Hresp=1, then Hreadyout=1/Hresp=1, then IDLE; Pselx stays 0 throughout.
- Idle/BUSY: Htrans=00 or 01 with a valid Haddr for 5 cycles -> Hreadyout=1, Hresp=0, no Pselx activity.
- Reset mid-access: assert Hreset in ENABLE with Pready=0 -> next edge Pselx=0, Penable=0, Hreadyout=1, Hrdata=0; a fresh write then completes normally.
